// File: rtl/clint_ctrl_if.sv
// Bundle between the execute stage, the CSR file and the clint trap sequencer.
// The slave side is the controller; the master side drives the pipeline/CSR views.
interface clint_ctrl_if #(
   parameter int CPU_WIDTH      = 32,
   parameter int CSR_ADDR_WIDTH = 12
);
   logic [CPU_WIDTH-1:0]      inst_i;
   logic [CPU_WIDTH-1:0]      inst_addr_i;
   logic                      jump_flag_i;
   logic [CPU_WIDTH-1:0]      jump_addr_i;
   logic                      irq_i;
   logic [CPU_WIDTH-1:0]      csr_mtvec_i;
   logic [CPU_WIDTH-1:0]      csr_mepc_i;
   logic [CPU_WIDTH-1:0]      csr_mstatus_i;
   logic                      clint_csr_wr_en_o;
   logic [CSR_ADDR_WIDTH-1:0] clint_csr_wr_addr_o;
   logic [CPU_WIDTH-1:0]      clint_csr_wr_data_o;
   logic                      hold_flag_o;
   logic                      int_assert_o;
   logic [CPU_WIDTH-1:0]      int_addr_o;

   modport master (
      output inst_i,
      output inst_addr_i,
      output jump_flag_i,
      output jump_addr_i,
      output irq_i,
      output csr_mtvec_i,
      output csr_mepc_i,
      output csr_mstatus_i,
      input  clint_csr_wr_en_o,
      input  clint_csr_wr_addr_o,
      input  clint_csr_wr_data_o,
      input  hold_flag_o,
      input  int_assert_o,
      input  int_addr_o
   );

   modport slave (
      input  inst_i,
      input  inst_addr_i,
      input  jump_flag_i,
      input  jump_addr_i,
      input  irq_i,
      input  csr_mtvec_i,
      input  csr_mepc_i,
      input  csr_mstatus_i,
      output clint_csr_wr_en_o,
      output clint_csr_wr_addr_o,
      output clint_csr_wr_data_o,
      output hold_flag_o,
      output int_assert_o,
      output int_addr_o
   );
endinterface

// File: rtl/clint_ctrl.sv
// Core-local trap sequencer: detects ECALL/EBREAK/MRET/timer irq in execute,
// writes mepc/mstatus/mcause one per cycle, stalls, then redirects the PC.
module clint_ctrl #(
   parameter int CPU_WIDTH      = 32,
   parameter int CSR_ADDR_WIDTH = 12
) (
   input  logic       clk,
   input  logic       rst_n,
   clint_ctrl_if.slave bus
);

   localparam logic [CSR_ADDR_WIDTH-1:0] A_MSTATUS =
      CSR_ADDR_WIDTH'(12'h300);
   localparam logic [CSR_ADDR_WIDTH-1:0] A_MEPC =
      CSR_ADDR_WIDTH'(12'h341);
   localparam logic [CSR_ADDR_WIDTH-1:0] A_MCAUSE =
      CSR_ADDR_WIDTH'(12'h342);

   localparam logic [CPU_WIDTH-1:0] I_ECALL =
      CPU_WIDTH'(32'h0000_0073);
   localparam logic [CPU_WIDTH-1:0] I_EBREAK =
      CPU_WIDTH'(32'h0010_0073);
   localparam logic [CPU_WIDTH-1:0] I_MRET =
      CPU_WIDTH'(32'h3020_0073);

   localparam logic [CPU_WIDTH-1:0] C_ECALL =
      CPU_WIDTH'(32'd11);
   localparam logic [CPU_WIDTH-1:0] C_EBREAK =
      CPU_WIDTH'(32'd3);
   localparam logic [CPU_WIDTH-1:0] C_TIMER =
      CPU_WIDTH'(32'h8000_0007);

   typedef enum logic [2:0] {
      IDLE,
      W_MEPC,
      W_MSTATUS,
      W_MCAUSE,
      ASSERT,
      R_MSTATUS,
      R_ASSERT
   } state_t;

   state_t               state;
   state_t               state_d;
   logic [CPU_WIDTH-1:0] epc_q;
   logic [CPU_WIDTH-1:0] epc_d;
   logic [CPU_WIDTH-1:0] cause_q;
   logic [CPU_WIDTH-1:0] cause_d;

   logic                 is_ecall;
   logic                 is_ebreak;
   logic                 is_mret;
   logic                 irq_ev;
   logic                 idle;
   logic                 event_det;
   logic [CPU_WIDTH-1:0] ms_trap;
   logic [CPU_WIDTH-1:0] ms_mret;
   logic [CPU_WIDTH-1:0] irq_epc;

   always_comb begin
      is_ecall  = (bus.inst_i == I_ECALL);
      is_ebreak = (bus.inst_i == I_EBREAK);
      is_mret   = (bus.inst_i == I_MRET);
      // irq only wins when no instruction event is present
      irq_ev    = bus.irq_i & bus.csr_mstatus_i[3]
                & ~is_ecall & ~is_ebreak & ~is_mret;
      idle      = (state == IDLE);
      event_det = rst_n & idle
                & (is_ecall | is_ebreak | is_mret | irq_ev);
      irq_epc   = bus.jump_flag_i ? bus.jump_addr_i
                                  : bus.inst_addr_i;
   end

   always_comb begin
      ms_trap    = bus.csr_mstatus_i;
      ms_trap[7] = bus.csr_mstatus_i[3];
      ms_trap[3] = 1'b0;
      ms_mret    = bus.csr_mstatus_i;
      ms_mret[3] = bus.csr_mstatus_i[7];
      ms_mret[7] = 1'b1;
   end

   always_comb begin
      state_d = state;
      epc_d   = epc_q;
      cause_d = cause_q;
      unique case (state)
         IDLE: begin
            if (event_det) begin
               unique case (1'b1)
                  is_ecall: begin
                     state_d = W_MEPC;
                     epc_d   = bus.inst_addr_i;
                     cause_d = C_ECALL;
                  end
                  is_ebreak: begin
                     state_d = W_MEPC;
                     epc_d   = bus.inst_addr_i;
                     cause_d = C_EBREAK;
                  end
                  is_mret: begin
                     state_d = R_MSTATUS;
                  end
                  irq_ev: begin
                     state_d = W_MEPC;
                     epc_d   = irq_epc;
                     cause_d = C_TIMER;
                  end
                  default: ;
               endcase
            end
         end
         W_MEPC:    state_d = W_MSTATUS;
         W_MSTATUS: state_d = W_MCAUSE;
         W_MCAUSE:  state_d = ASSERT;
         ASSERT:    state_d = IDLE;
         R_MSTATUS: state_d = R_ASSERT;
         R_ASSERT:  state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         epc_q   <= '0;
         cause_q <= '0;
      end else begin
         state   <= state_d;
         epc_q   <= epc_d;
         cause_q <= cause_d;
      end
   end

   always_comb begin
      bus.clint_csr_wr_en_o   = 1'b0;
      bus.clint_csr_wr_addr_o = '0;
      bus.clint_csr_wr_data_o = '0;
      bus.int_assert_o        = 1'b0;
      bus.int_addr_o          = '0;
      bus.hold_flag_o         = ~idle | event_det;
      unique case (state)
         W_MEPC: begin
            bus.clint_csr_wr_en_o   = 1'b1;
            bus.clint_csr_wr_addr_o = A_MEPC;
            bus.clint_csr_wr_data_o = epc_q;
         end
         W_MSTATUS: begin
            bus.clint_csr_wr_en_o   = 1'b1;
            bus.clint_csr_wr_addr_o = A_MSTATUS;
            bus.clint_csr_wr_data_o = ms_trap;
         end
         W_MCAUSE: begin
            bus.clint_csr_wr_en_o   = 1'b1;
            bus.clint_csr_wr_addr_o = A_MCAUSE;
            bus.clint_csr_wr_data_o = cause_q;
         end
         ASSERT: begin
            bus.int_assert_o = 1'b1;
            bus.int_addr_o   = bus.csr_mtvec_i;
         end
         R_MSTATUS: begin
            bus.clint_csr_wr_en_o   = 1'b1;
            bus.clint_csr_wr_addr_o = A_MSTATUS;
            bus.clint_csr_wr_data_o = ms_mret;
         end
         R_ASSERT: begin
            bus.int_assert_o = 1'b1;
            bus.int_addr_o   = bus.csr_mepc_i;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_clint_ctrl.sv
// Scoreboard bench for clint_ctrl: a behavioural trap model predicts CSR
// writes, redirects and stall per cycle; a negedge monitor compares.
module tb_clint_ctrl;

   localparam logic [31:0] ECALL  = 32'h0000_0073;
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [31:0] MRET   = 32'h3020_0073;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   clint_ctrl_if #(.CPU_WIDTH(32), .CSR_ADDR_WIDTH(12)) bus ();

   clint_ctrl #(.CPU_WIDTH(32), .CSR_ADDR_WIDTH(12)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      bit          redir;
      logic [11:0] addr;
      logic [31:0] data;
      int          cyc;
   } ev_t;

   typedef struct {
      bit h;
      int cyc;
   } hold_t;

   ev_t   exp_q[$];
   hold_t hold_q[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int free_cyc = 0;

   // CSR file seen by the controller, updated from its own write port
   logic [31:0] mtvec, mepc, mstatus, mcause;

   bit          p_en = 0;
   logic [31:0] p_ms, p_mepc, p_mtvec;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string nm, logic [31:0] act,
                               logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %h expected %h",
                  nm, cyc, act, req);
      end
   endfunction

   function automatic void push_w(int c, logic [11:0] a, logic [31:0] d);
      ev_t e;
      e.redir = 0; e.addr = a; e.data = d; e.cyc = c;
      exp_q.push_back(e);
   endfunction

   function automatic void push_r(int c, logic [31:0] d);
      ev_t e;
      e.redir = 1; e.addr = '0; e.data = d; e.cyc = c;
      exp_q.push_back(e);
   endfunction

   function automatic void trap(int c, logic [31:0] epc, logic [31:0] cause);
      logic [31:0] ms;
      ms = (mstatus & ~32'h88) | (mstatus[3] ? 32'h80 : 32'h0);
      push_w(c + 1, 12'h341, epc);
      push_w(c + 2, 12'h300, ms);
      push_w(c + 3, 12'h342, cause);
      push_r(c + 4, mtvec);
      free_cyc = c + 5;
   endfunction

   function automatic void mret_ev(int c);
      logic [31:0] ms;
      ms = (mstatus & ~32'h8) | (mstatus[7] ? 32'h8 : 32'h0) | 32'h80;
      push_w(c + 1, 12'h300, ms);
      push_r(c + 2, mepc);
      free_cyc = c + 3;
   endfunction

   function automatic void decide(logic [31:0] inst, logic [31:0] pc,
                                  logic jf, logic [31:0] ja, logic irq);
      hold_t h;
      if (!rst_n) begin
         exp_q.delete();
         free_cyc = cyc;
      end else if (cyc >= free_cyc) begin
         if (inst == ECALL) trap(cyc, pc, 32'd11);
         else if (inst == EBREAK) trap(cyc, pc, 32'd3);
         else if (inst == MRET) mret_ev(cyc);
         else if (irq && mstatus[3])
            trap(cyc, jf ? ja : pc, 32'h8000_0007);
      end
      h.h = (cyc < free_cyc);
      h.cyc = cyc;
      hold_q.push_back(h);
   endfunction

   task automatic step(input logic [31:0] inst, input logic [31:0] pc,
                       input logic jf, input logic [31:0] ja,
                       input logic irq, input logic rst = 1'b1);
      logic        sw_en;
      logic [11:0] sw_a;
      logic [31:0] sw_d;
      @(negedge clk);
      sw_en = bus.clint_csr_wr_en_o;
      sw_a  = bus.clint_csr_wr_addr_o;
      sw_d  = bus.clint_csr_wr_data_o;
      @(posedge clk);
      #1;
      if (sw_en) begin
         case (sw_a)
            12'h341: mepc = sw_d;
            12'h300: mstatus = sw_d;
            12'h342: mcause = sw_d;
            default: ;
         endcase
      end
      if (p_en && cyc >= free_cyc) begin
         mstatus = p_ms;
         mepc    = p_mepc;
         mtvec   = p_mtvec;
      end
      p_en = 0;
      bus.csr_mtvec_i   = mtvec;
      bus.csr_mepc_i    = mepc;
      bus.csr_mstatus_i = mstatus;
      bus.inst_i        = inst;
      bus.inst_addr_i   = pc;
      bus.jump_flag_i   = jf;
      bus.jump_addr_i   = ja;
      bus.irq_i         = irq;
      rst_n             = rst;
      decide(inst, pc, jf, ja, irq);
   endtask

   task automatic set_csr(input logic [31:0] ms, input logic [31:0] ep,
                          input logic [31:0] tv);
      p_en = 1; p_ms = ms; p_mepc = ep; p_mtvec = tv;
   endtask

   task automatic idle_n(input int n, input logic irq = 1'b0);
      for (int i = 0; i < n; i++) step(NOP, 32'h0, 1'b0, 32'h0, irq);
   endtask

   always @(negedge clk) begin
      while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
         checks++; errors++;
         $display("FAIL missed_event @cyc %0d: got none expected %s %h at cyc %0d",
                  cyc, exp_q[0].redir ? "redirect" : "write",
                  exp_q[0].data, exp_q[0].cyc);
         void'(exp_q.pop_front());
      end
      if (!rst_n) begin
         chk("reset_outputs",
             {31'h0, bus.clint_csr_wr_en_o | bus.hold_flag_o
                   | bus.int_assert_o | (|bus.clint_csr_wr_addr_o)
                   | (|bus.clint_csr_wr_data_o) | (|bus.int_addr_o)},
             32'h0);
      end
      if (hold_q.size() != 0 && hold_q[0].cyc == cyc) begin
         hold_t h;
         h = hold_q.pop_front();
         chk("hold_flag", {31'h0, bus.hold_flag_o}, {31'h0, h.h});
      end
      if (bus.clint_csr_wr_en_o) begin
         if (exp_q.size() == 0 || exp_q[0].cyc != cyc || exp_q[0].redir) begin
            checks++; errors++;
            $display("FAIL unexpected_write @cyc %0d: got addr %h data %h expected none",
                     cyc, bus.clint_csr_wr_addr_o, bus.clint_csr_wr_data_o);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            chk("wr_addr", {20'h0, bus.clint_csr_wr_addr_o}, {20'h0, e.addr});
            chk("wr_data", bus.clint_csr_wr_data_o, e.data);
         end
      end else begin
         chk("idle_wr_bus",
             {20'h0, bus.clint_csr_wr_addr_o} | bus.clint_csr_wr_data_o,
             32'h0);
      end
      if (bus.int_assert_o) begin
         if (exp_q.size() == 0 || exp_q[0].cyc != cyc || !exp_q[0].redir) begin
            checks++; errors++;
            $display("FAIL unexpected_redirect @cyc %0d: got addr %h expected none",
                     cyc, bus.int_addr_o);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            chk("int_addr", bus.int_addr_o, e.data);
         end
      end
   end

   initial begin
      mtvec = 32'h800; mepc = 32'h0; mstatus = 32'h8; mcause = 32'h0;
      bus.inst_i = NOP; bus.inst_addr_i = '0; bus.jump_flag_i = 0;
      bus.jump_addr_i = '0; bus.irq_i = 0;
      bus.csr_mtvec_i = mtvec; bus.csr_mepc_i = mepc;
      bus.csr_mstatus_i = mstatus;

      for (int i = 0; i < 3; i++) step(ECALL, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
      idle_n(2);

      set_csr(32'h8, 32'h0, 32'h800);
      step(ECALL, 32'h100, 1'b0, 32'h0, 1'b0);
      idle_n(5);
      chk("t1_mepc", mepc, 32'h100);
      chk("t1_mstatus", mstatus, 32'h80);
      chk("t1_mcause", mcause, 32'd11);

      set_csr(32'h80, 32'h104, 32'h800);
      step(MRET, 32'h900, 1'b0, 32'h0, 1'b0);
      idle_n(3);
      chk("t2_mstatus", mstatus, 32'h88);

      set_csr(32'h0, 32'h104, 32'h800);
      idle_n(4, 1'b1);
      set_csr(32'h8, 32'h104, 32'h800);
      idle_n(1, 1'b1);
      idle_n(5);
      chk("t3_mcause", mcause, 32'h8000_0007);

      set_csr(32'h8, 32'h0, 32'h800);
      step(NOP, 32'h300, 1'b1, 32'h200, 1'b1);
      idle_n(5);
      chk("t4_mepc", mepc, 32'h200);

      set_csr(32'h8, 32'h0, 32'h800);
      step(ECALL, 32'h400, 1'b0, 32'h0, 1'b1);
      idle_n(6, 1'b1);
      chk("t5_mcause", mcause, 32'd11);
      set_csr(32'h8, 32'h0, 32'h800);
      idle_n(6, 1'b1);
      chk("t5_irq_mcause", mcause, 32'h8000_0007);

      step(ECALL, 32'h800, 1'b0, 32'h0, 1'b0);
      idle_n(4);
      step(ECALL, 32'h800, 1'b0, 32'h0, 1'b0);
      idle_n(5);

      set_csr(32'h8, 32'h0, 32'h800);
      step(ECALL, 32'h500, 1'b0, 32'h0, 1'b0);
      step(NOP, 32'h0, 1'b0, 32'h0, 1'b0);
      step(ECALL, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
      step(ECALL, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
      idle_n(3);
      chk("t6_mepc_kept", mepc, 32'h500);
      chk("t6_mstatus_kept", mstatus, 32'h8);

      for (int i = 0; i < 600; i++) begin
         logic [31:0] inst;
         int k;
         k = $urandom_range(0, 9);
         case (k)
            0: inst = ECALL;
            1: inst = EBREAK;
            2, 3: inst = MRET;
            4: inst = $urandom;
            default: inst = NOP;
         endcase
         if ($urandom_range(0, 7) == 0)
            set_csr($urandom, {$urandom_range(0, 32'hfff), 2'b00},
                    {$urandom_range(0, 32'hfff), 2'b00});
         step(inst, {$urandom_range(0, 32'hffff), 2'b00},
              1'($urandom_range(0, 1)),
              {$urandom_range(0, 32'hffff), 2'b00},
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 99) != 0));
      end
      idle_n(8);
      chk("queue_drained", exp_q.size(), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
